// File: rtl/vx_tcu_drl_exp_align.sv
// TCU DRL max-exponent and alignment-shift stage.
// Two-stage elastic pipeline: S1 finds the max exponent, S2 derives saturated shifts.
module vx_tcu_drl_exp_align #(
    parameter int N       = 2,
    parameter int TCK     = 2 * N,
    parameter int EXP_W   = 10,
    parameter int SHIFT_W = 6,
    parameter int TAG_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [(TCK+1)*EXP_W-1:0]     raw_exp_y,
    input  logic [TCK:0]                 term_zero,
    input  logic [TAG_W-1:0]             tag_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [EXP_W-1:0]             max_exp,
    output logic [(TCK+1)*SHIFT_W-1:0]   shift_amt,
    output logic [TCK:0]                 term_live,
    output logic                         all_zero,
    output logic [TAG_W-1:0]             tag_out
);
    localparam int TERMS = TCK + 1;
    localparam int LVLS  = $clog2(TERMS);
    localparam logic [EXP_W-1:0]   SAT_E = EXP_W'((1 << SHIFT_W) - 1);
    localparam logic [SHIFT_W-1:0] SAT_S = '1;

    // Pairwise reduction, one level per iteration, keeps the tree balanced.
    function automatic logic [EXP_W-1:0] tree_max(input logic [TERMS*EXP_W-1:0] v);
        logic [EXP_W-1:0] node [TERMS];
        int cnt;
        for (int i = 0; i < TERMS; i++) node[i] = v[i*EXP_W +: EXP_W];
        cnt = TERMS;
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < TERMS; i++) begin
                if (2*i + 1 < cnt)
                    node[i] = (node[2*i] > node[2*i+1]) ? node[2*i] : node[2*i+1];
                else if (2*i < cnt)
                    node[i] = node[2*i];
            end
            cnt = (cnt + 1) / 2;
        end
        return node[0];
    endfunction

    logic                      v1, v2;
    logic                      s1_adv, s2_adv;
    logic [TERMS*EXP_W-1:0]    me_n, me_q;
    logic [EXP_W-1:0]          mx_n, mx_q;
    logic [TCK:0]              tz_q;
    logic [TAG_W-1:0]          tag_q;

    logic [EXP_W-1:0]          d;
    logic [TERMS*SHIFT_W-1:0]  sh_n;
    logic [TCK:0]              live_n;
    logic                      az_n;
    logic [EXP_W-1:0]          mxo_n;

    assign s2_adv    = ~v2 | ready_out;
    assign s1_adv    = ~v1 | s2_adv;
    assign ready_in  = s1_adv;
    assign valid_out = v2;

    always_comb begin
        me_n = '0;
        for (int i = 0; i < TERMS; i++)
            me_n[i*EXP_W +: EXP_W] = term_zero[i] ? '0 : raw_exp_y[i*EXP_W +: EXP_W];
        mx_n = tree_max(me_n);
    end

    // Zeroed terms carry me=0 <= mx, so d never wraps.
    always_comb begin
        d      = '0;
        sh_n   = '0;
        live_n = '0;
        az_n   = &tz_q;
        mxo_n  = az_n ? '0 : mx_q;
        for (int i = 0; i < TERMS; i++) begin
            d = mx_q - me_q[i*EXP_W +: EXP_W];
            sh_n[i*SHIFT_W +: SHIFT_W] =
                (tz_q[i] | (d >= SAT_E)) ? SAT_S : d[SHIFT_W-1:0];
            live_n[i] = ~tz_q[i] & (d < SAT_E);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            me_q      <= '0;
            mx_q      <= '0;
            tz_q      <= '0;
            tag_q     <= '0;
            max_exp   <= '0;
            shift_amt <= '0;
            term_live <= '0;
            all_zero  <= 1'b0;
            tag_out   <= '0;
        end else begin
            if (s1_adv) v1 <= valid_in;
            if (s2_adv) v2 <= v1;
            if (valid_in & s1_adv) begin
                me_q  <= me_n;
                mx_q  <= mx_n;
                tz_q  <= term_zero;
                tag_q <= tag_in;
            end
            if (v1 & s2_adv) begin
                max_exp   <= mxo_n;
                shift_amt <= sh_n;
                term_live <= live_n;
                all_zero  <= az_n;
                tag_out   <= tag_q;
            end
        end
    end
endmodule
